hazard_ctrl_p: RTL and testbench
================================

Name: hazard_ctrl_p

Overview:
Parametrised, stateful pipeline hazard controller for the RV32 five-stage core. It replaces the purely combinational load-use detector. It adds:
- configurable source-operand count and load-use latency,
- multi-cycle stall sequencing,
- branch-redirect flushing,
- a data-memory-busy global freeze,
- a saturating stall-cycle performance counter.

It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.

Parameters:
REG_AW, 5, register address width.
NUM_SRC, 2, source operands checked per ID instruction (1..3).
LOAD_LAT, 1, bubbles required after a load before a dependent may leave ID (1..7).
CNT_W, 16, stall performance counter width.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_rs  in  NUM_SRC*REG_AW  ID source register addresses; src i at bits [i*REG_AW +: REG_AW].
id_rs_used  in  NUM_SRC  bit i=1: src i actually read by the ID instruction.
ex_rd  in  REG_AW  destination of the EX instruction.
ex_mem_read  in  1  EX instruction is a load.
ex_reg_wen  in  1  EX instruction writes the register file.
redirect  in  1  EX resolved a taken branch or jump this cycle.
dmem_busy  in  1  data memory not ready; pipeline must freeze.
pc_wen  out  1  PC register write enable.
ifid_wen  out  1  IF/ID register write enable.
ifid_flush  out  1  clear IF/ID to NOP.
idex_flush  out  1  insert bubble into ID/EX.
exmem_wen  out  1  EX/MEM (and later stages) write enable.
stall  out  1  status: load-use stall active this cycle.
stall_count  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:

Hazard detection
- Combinational hazard condition: ex_mem_read & ex_reg_wen & (ex_rd != 0) & (for some i: id_rs_used[i] & id_rs[i] == ex_rd).
- x0 never causes a hazard.
- Unused sources never cause a hazard.

State
- FSM states: IDLE, STALL.
- Down-counter cnt, width 3.

Priority per cycle (highest first); all outputs are combinational from state and inputs:
1. rst_n=0 (asynchronous):
   - state=IDLE, cnt=0, stall_count=0.
   - Outputs forced: pc_wen=0, ifid_wen=0, exmem_wen=0, ifid_flush=1, idex_flush=1, stall=0.
2. dmem_busy=1 (freeze):
   - pc_wen=0, ifid_wen=0, exmem_wen=0, ifid_flush=0, idex_flush=0, stall=0.
   - state, cnt and stall_count hold.
   - redirect and hazard are ignored this cycle.
3. redirect=1:
   - pc_wen=1, ifid_wen=1, exmem_wen=1, ifid_flush=1, idex_flush=1, stall=0.
   - next state=IDLE, cnt=0. Aborts any pending stall.
4. state=STALL:
   - pc_wen=0, ifid_wen=0, idex_flush=1, ifid_flush=0, exmem_wen=1, stall=1.
   - If cnt==1: next IDLE, cnt=0. Else cnt=cnt-1, stay STALL.
5. state=IDLE with hazard:
   - Same outputs as STALL.
   - If LOAD_LAT>1: next STALL, cnt=LOAD_LAT-1. Otherwise stay IDLE.
6. Otherwise (normal flow):
   - pc_wen=1, ifid_wen=1, exmem_wen=1, flushes=0, stall=0.

Timing and counters
- Total bubbles per load-use event = LOAD_LAT, counting only non-frozen cycles.
- Hazard is not re-evaluated while in STALL.
- stall_count increments by 1 on each rising edge where stall=1; it holds at all-ones (saturates).

Reset and parameters
- Reset deassertion mid-stall: the block restarts in IDLE with no residual stall.
- Out-of-range parameter values (LOAD_LAT outside 1..7, NUM_SRC outside 1..3) are illegal. Simulation elaboration must flag them.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 with arbitrary inputs.
   - Required: pc_wen=0, ifid_wen=0, exmem_wen=0, ifid_flush=1, idex_flush=1, stall=0, stall_count=0.
   - After release with no hazard: pc_wen=1, ifid_wen=1, exmem_wen=1, flushes=0.
2. Basic load-use, LOAD_LAT=1:
   - Stimulus: ex_rd=5, load, wen; id_rs={5,3}, used=2'b11.
   - Required: one cycle of stall=1, pc_wen=0, idex_flush=1; next cycle (EX now a bubble) normal flow; stall_count=1.
   - Repeat with used=2'b00 or ex_rd=0: no stall.
3. LOAD_LAT=3, NUM_SRC=3:
   - Stimulus: hazard on src 2 only.
   - Required: exactly 3 consecutive stall cycles, then normal flow; stall_count=3.
4. Freeze mid-stall, LOAD_LAT=3:
   - Stimulus: dmem_busy=1 for 2 cycles during the second stall cycle.
   - Required: all wen=0 and no flush while frozen; cnt held; total stall=1 cycles still 3; stall_count=3.
5. Redirect interactions, LOAD_LAT=3:
   - Stimulus A: redirect=1 in the second stall cycle.
   - Required A: ifid_flush=1, idex_flush=1, pc_wen=1 that cycle; IDLE next cycle; stall_count=1.
   - Stimulus B: redirect coincident with a hazard in IDLE.
   - Required B: redirect wins; no stall.
6. Counter saturation and async reset:
   - Stimulus: CNT_W=4, 20 stall cycles.
   - Required: stall_count sticks at 15.
   - Stimulus: assert rst_n mid-STALL between clock edges.
   - Required: outputs go to reset values immediately; normal flow after release.

Source files
------------

// File: rtl/hazard_ctrl_p.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_p
// Stateful pipeline hazard controller for the RV32 five-stage core. It detects
// load-use hazards against the instruction in EX, sequences multi-cycle stalls
// of LOAD_LAT bubbles, flushes IF/ID and ID/EX on a branch redirect, freezes
// the whole pipeline while data memory is busy, and counts stall cycles in a
// saturating performance counter.
//
// Parameters:
//   REG_AW   register address width
//   NUM_SRC  source operands checked per ID instruction (1..3)
//   LOAD_LAT bubbles required after a load before a dependent leaves ID (1..7)
//   CNT_W    stall performance counter width
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   id_rs        ID source register addresses, src i at [i*REG_AW +: REG_AW]
//   id_rs_used   bit i set: src i is actually read by the ID instruction
//   ex_rd        destination register of the EX instruction
//   ex_mem_read  EX instruction is a load
//   ex_reg_wen   EX instruction writes the register file
//   redirect     EX resolved a taken branch/jump this cycle
//   dmem_busy    data memory not ready, pipeline freezes
//   pc_wen       PC write enable
//   ifid_wen     IF/ID write enable
//   ifid_flush   clear IF/ID to NOP
//   idex_flush   insert bubble into ID/EX
//   exmem_wen    EX/MEM (and later stages) write enable
//   stall        load-use stall active this cycle
//   stall_count  saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module hazard_ctrl_p #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_reg_wen,
    input  logic                      redirect,
    input  logic                      dmem_busy,
    output logic                      pc_wen,
    output logic                      ifid_wen,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      exmem_wen,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count
);

    // Illegal parameter values stop elaboration.
    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
            $error("hazard_ctrl_p: LOAD_LAT=%0d outside 1..7", LOAD_LAT);
        end
        if (NUM_SRC < 1 || NUM_SRC > 3) begin : g_bad_num_src
            $error("hazard_ctrl_p: NUM_SRC=%0d outside 1..3", NUM_SRC);
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // Remaining bubbles after the first one, loaded on hazard entry.
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [CNT_W-1:0]  r_stall_count;
    logic [NUM_SRC-1:0] w_src_match;
    logic              w_hazard;

    // Per-source comparison against the EX destination.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_match[gi] = id_rs_used[gi] &
                                     (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
        end
    endgenerate

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_hazard = ex_mem_read & ex_reg_wen & (ex_rd != '0) & (|w_src_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        // Normal flow defaults.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        exmem_wen    = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        stall        = 1'b0;

        if (!rst_n) begin
            // Outputs follow reset immediately, not at the next edge.
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            exmem_wen  = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (dmem_busy) begin
            // Full freeze: nothing advances, state and counters hold.
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            exmem_wen = 1'b0;
        end else if (redirect) begin
            // Wrong-path instructions in IF/ID and ID are squashed; any
            // pending stall belongs to a squashed instruction and is dropped.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = 3'd0;
        end else if (r_state == STALL) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
            stall      = 1'b1;
            if (r_cnt == 3'd1) begin
                w_state_next = IDLE;
                w_cnt_next   = 3'd0;
            end else begin
                w_cnt_next = r_cnt - 3'd1;
            end
        end else if (w_hazard) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
            stall      = 1'b1;
            // The first bubble is issued here; STALL covers the rest.
            if (LOAD_LAT > 1) begin
                w_state_next = STALL;
                w_cnt_next   = LAT_M1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_p
// Directed bench for hazard_ctrl_p. Two instances:
//   u_a : NUM_SRC=2, LOAD_LAT=1, CNT_W=16
//   u_b : NUM_SRC=3, LOAD_LAT=3, CNT_W=4
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge. Output vector order: {pc_wen, ifid_wen, exmem_wen,
// ifid_flush, idex_flush, stall}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_p;

    localparam logic [5:0] O_NORMAL = 6'b111000;
    localparam logic [5:0] O_STALL  = 6'b001011;
    localparam logic [5:0] O_RESET  = 6'b000110;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_REDIR  = 6'b111110;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A signals
    logic [9:0]  a_id_rs;
    logic [1:0]  a_id_rs_used;
    logic [4:0]  a_ex_rd;
    logic        a_ex_mem_read, a_ex_reg_wen, a_redirect, a_dmem_busy;
    logic        a_pc_wen, a_ifid_wen, a_ifid_flush, a_idex_flush, a_exmem_wen, a_stall;
    logic [15:0] a_stall_count;
    logic [5:0]  a_o;

    // Instance B signals
    logic [14:0] b_id_rs;
    logic [2:0]  b_id_rs_used;
    logic [4:0]  b_ex_rd;
    logic        b_ex_mem_read, b_ex_reg_wen, b_redirect, b_dmem_busy;
    logic        b_pc_wen, b_ifid_wen, b_ifid_flush, b_idex_flush, b_exmem_wen, b_stall;
    logic [3:0]  b_stall_count;
    logic [5:0]  b_o;

    assign a_o = {a_pc_wen, a_ifid_wen, a_exmem_wen, a_ifid_flush, a_idex_flush, a_stall};
    assign b_o = {b_pc_wen, b_ifid_wen, b_exmem_wen, b_ifid_flush, b_idex_flush, b_stall};

    hazard_ctrl_p #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs(a_id_rs), .id_rs_used(a_id_rs_used), .ex_rd(a_ex_rd),
        .ex_mem_read(a_ex_mem_read), .ex_reg_wen(a_ex_reg_wen),
        .redirect(a_redirect), .dmem_busy(a_dmem_busy),
        .pc_wen(a_pc_wen), .ifid_wen(a_ifid_wen), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .exmem_wen(a_exmem_wen), .stall(a_stall),
        .stall_count(a_stall_count)
    );

    hazard_ctrl_p #(.REG_AW(5), .NUM_SRC(3), .LOAD_LAT(3), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs(b_id_rs), .id_rs_used(b_id_rs_used), .ex_rd(b_ex_rd),
        .ex_mem_read(b_ex_mem_read), .ex_reg_wen(b_ex_reg_wen),
        .redirect(b_redirect), .dmem_busy(b_dmem_busy),
        .pc_wen(b_pc_wen), .ifid_wen(b_ifid_wen), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_wen(b_exmem_wen), .stall(b_stall),
        .stall_count(b_stall_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("check %s ok (%0h)", tag, got);
        end
    endtask

    // One B cycle: drive, check outputs and counter, advance past the edge.
    task automatic step_b(input string tag, input logic load, input logic busy,
                          input logic redir, input logic [5:0] exp_o,
                          input logic [3:0] exp_cnt);
        b_ex_mem_read = load;
        b_dmem_busy   = busy;
        b_redirect    = redir;
        @(negedge clk);
        check_val({tag, "_out"}, 32'(b_o), 32'(exp_o));
        check_val({tag, "_cnt"}, 32'(b_stall_count), 32'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with hostile inputs on A: hazard, busy and redirect all active.
        rst_n         = 1'b0;
        a_id_rs       = {5'd3, 5'd5};
        a_id_rs_used  = 2'b11;
        a_ex_rd       = 5'd5;
        a_ex_mem_read = 1'b1;
        a_ex_reg_wen  = 1'b1;
        a_redirect    = 1'b1;
        a_dmem_busy   = 1'b1;
        b_id_rs       = {5'd7, 5'd2, 5'd1};
        b_id_rs_used  = 3'b111;
        b_ex_rd       = 5'd7;
        b_ex_mem_read = 1'b0;
        b_ex_reg_wen  = 1'b1;
        b_redirect    = 1'b0;
        b_dmem_busy   = 1'b0;
        #2;
        check_val("rst_a_out", 32'(a_o), 32'(O_RESET));
        check_val("rst_a_cnt", 32'(a_stall_count), 32'd0);
        check_val("rst_b_out", 32'(b_o), 32'(O_RESET));
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        a_ex_mem_read = 1'b0;
        a_redirect    = 1'b0;
        a_dmem_busy   = 1'b0;
        @(negedge clk);
        check_val("rel_a_out", 32'(a_o), 32'(O_NORMAL));
        @(posedge clk);
        #1;

        // Basic load-use on A (LOAD_LAT=1): src0=5 matches.
        a_ex_mem_read = 1'b1;
        @(negedge clk);
        check_val("lu1_stall", 32'(a_o), 32'(O_STALL));
        @(posedge clk);
        #1;
        a_ex_mem_read = 1'b0;   // EX now holds the bubble
        a_ex_rd       = 5'd0;
        @(negedge clk);
        check_val("lu1_after", 32'(a_o), 32'(O_NORMAL));
        check_val("lu1_cnt", 32'(a_stall_count), 32'd1);
        // Unused sources: no hazard.
        a_ex_rd       = 5'd5;
        a_ex_mem_read = 1'b1;
        a_id_rs_used  = 2'b00;
        #1;
        check_val("unused_src", 32'(a_o), 32'(O_NORMAL));
        // x0 destination: no hazard.
        a_id_rs_used  = 2'b11;
        a_id_rs       = {5'd3, 5'd0};
        a_ex_rd       = 5'd0;
        #1;
        check_val("x0_dest", 32'(a_o), 32'(O_NORMAL));
        // Second source matches, but EX does not write the register file.
        a_id_rs       = {5'd9, 5'd4};
        a_ex_rd       = 5'd9;
        a_ex_reg_wen  = 1'b0;
        #1;
        check_val("no_wen", 32'(a_o), 32'(O_NORMAL));
        a_ex_reg_wen  = 1'b1;
        #1;
        check_val("src1_hit", 32'(a_o), 32'(O_STALL));
        a_ex_mem_read = 1'b0;
        @(posedge clk);
        #1;
        check_val("lu1_cnt2", 32'(a_stall_count), 32'd1);

        // LOAD_LAT=3, NUM_SRC=3, hazard on src 2 only.
        do_reset();
        step_b("ll3_c1", 1'b1, 1'b0, 1'b0, O_STALL,  4'd0);
        step_b("ll3_c2", 1'b0, 1'b0, 1'b0, O_STALL,  4'd1);
        step_b("ll3_c3", 1'b0, 1'b0, 1'b0, O_STALL,  4'd2);
        step_b("ll3_c4", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd3);
        step_b("ll3_c5", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd3);

        // Freeze for two cycles during the second stall cycle.
        do_reset();
        step_b("frz_c1", 1'b1, 1'b0, 1'b0, O_STALL,  4'd0);
        step_b("frz_c2", 1'b0, 1'b1, 1'b0, O_FREEZE, 4'd1);
        step_b("frz_c3", 1'b0, 1'b1, 1'b0, O_FREEZE, 4'd1);
        step_b("frz_c4", 1'b0, 1'b0, 1'b0, O_STALL,  4'd1);
        step_b("frz_c5", 1'b0, 1'b0, 1'b0, O_STALL,  4'd2);
        step_b("frz_c6", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd3);

        // Redirect in the second stall cycle aborts the stall.
        do_reset();
        step_b("rdA_c1", 1'b1, 1'b0, 1'b0, O_STALL,  4'd0);
        step_b("rdA_c2", 1'b0, 1'b0, 1'b1, O_REDIR,  4'd1);
        step_b("rdA_c3", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd1);

        // Redirect coincident with a hazard in IDLE wins.
        do_reset();
        step_b("rdB_c1", 1'b1, 1'b0, 1'b1, O_REDIR,  4'd0);
        step_b("rdB_c2", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd0);

        // Saturation: continuous load-use keeps stall high for 20 edges.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step_b($sformatf("sat_%0d", k), 1'b1, 1'b0, 1'b0, O_STALL,
                   (k > 15) ? 4'd15 : 4'(k - 1));
        end
        // Cycle 21 is a STALL-state bubble; assert reset between edges.
        @(negedge clk);
        check_val("sat_final", 32'(b_stall_count), 32'd15);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_out", 32'(b_o), 32'(O_RESET));
        check_val("arst_cnt", 32'(b_stall_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_b("post_c1", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd0);
        step_b("post_c2", 1'b0, 1'b0, 1'b0, O_NORMAL, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
